// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states,
// the latched request record and the byte-enable helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} mem_state_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
    logic       err;
  } mem_req_t;

  // Little-endian lane enables for a naturally aligned access.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << lane;
      SZ_HALF: lane_be = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word array: byte-enabled synchronous write, combinational read.
module data_mem_array #(
  parameter int DEPTH_WORDS = 16,
  parameter int AW          = 4
) (
  input  logic          clock,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++)
      if (be[b]) mem[idx][b] <= wdata[8*b +: 8];
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller: zero-fills the array after reset, then serves one
// request at a time with range/alignment checks and lane steering.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int          DEPTH_WORDS = 242688,
  parameter int          LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        clear_done
);

  localparam int          AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  mem_state_t    state, state_nx;
  mem_req_t      req_q;
  logic [AW-1:0] clr_cnt, widx_q, widx, arr_idx;
  logic [1:0]    wait_cnt;
  logic [3:0]    arr_be;
  logic [31:0]   arr_wdata, arr_rdata, st_data, off, sh, ld;
  logic          acc_err;

  // Offset is compared whole, so an address below BASE wraps to a huge value
  // and also lands out of range.
  assign off     = req_addr - BASE_ADDR;
  assign widx    = off[AW+1:2];
  assign acc_err = (req_size == SZ_RSVD)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (|req_addr[1:0]))
                 | (req_addr < BASE_ADDR)
                 | ({1'b0, off} >= SPAN);

  always_comb begin
    case (req_size)
      SZ_BYTE: st_data = {4{req_wdata[7:0]}};
      SZ_HALF: st_data = {2{req_wdata[15:0]}};
      default: st_data = req_wdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    arr_idx    = widx_q;
    arr_be     = 4'b0000;
    arr_wdata  = st_data;
    case (state)
      CLEAR: begin
        arr_idx   = clr_cnt;
        arr_be    = 4'b1111;
        arr_wdata = '0;
        if (clr_cnt == AW'(DEPTH_WORDS - 1)) state_nx = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // Store commits on the acceptance edge so a following load sees it.
          if (req_rw && !acc_err) begin
            arr_idx = widx;
            arr_be  = lane_be(req_size, req_addr[1:0]);
          end
          state_nx = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: if (int'(wait_cnt) == LATENCY - 2) state_nx = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_cnt    <= '0;
      wait_cnt   <= '0;
      widx_q     <= '0;
      req_q      <= '0;
      clear_done <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (state_nx == IDLE) clear_done <= 1'b1;
      end
      if (state == IDLE && req_valid) begin
        req_q.rw   <= req_rw;
        req_q.size <= req_size;
        req_q.uns  <= req_unsigned;
        req_q.lane <= req_addr[1:0];
        req_q.err  <= acc_err;
        widx_q     <= widx;
        wait_cnt   <= '0;
      end
      if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clock (clock),
    .idx   (arr_idx),
    .be    (arr_be),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    sh = arr_rdata >> {req_q.lane, 3'b000};
    case (req_q.size)
      SZ_BYTE: ld = req_q.uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: ld = req_q.uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ld = sh;
    endcase
  end

  assign resp_rdata = (resp_valid && !req_q.rw && !req_q.err) ? ld : '0;
  assign resp_err   = resp_valid & req_q.err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: LATENCY=1 and LATENCY=3 instances share stimulus and
// are checked against a byte-addressed reference memory.
module tb_data_mem_ctrl;
  import mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h3000;
  localparam int          DEPTH = 16;

  logic        clock = 1'b0, reset = 1'b1;
  logic        valid1 = 1'b0, valid3 = 1'b0;
  logic        req_rw = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rdy1, rv1, re1, cd1, rdy3, rv3, re3, cd3;
  logic [31:0] rd1, rd3;

  int checks = 0, failures = 0;
  logic [7:0] mm [0:4*DEPTH-1];

  always #5 clock = ~clock;

  data_mem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u1 (
    .clock(clock), .reset(reset), .req_valid(valid1), .req_ready(rdy1),
    .req_rw(req_rw), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
    .resp_rdata(rd1), .resp_err(re1), .clear_done(cd1));

  data_mem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u3 (
    .clock(clock), .reset(reset), .req_valid(valid3), .req_ready(rdy3),
    .req_rw(req_rw), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv3),
    .resp_rdata(rd3), .resp_err(re3), .clear_done(cd3));

  typedef struct {
    logic        rw;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4*DEPTH; i++) mm[i] = 8'h00;
  endtask

  // Reference: byte-addressed memory, applies stores and computes load results.
  task automatic model(input logic rw, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] d, output logic e);
    int n;
    logic [31:0] off, v;
    off = a - BASE;
    e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
        || (a < BASE) || (a >= BASE + 32'(4*DEPTH));
    d = '0;
    if (!e) begin
      n = 1 << sz;
      if (rw) begin
        for (int i = 0; i < n; i++) mm[off + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[off + i];
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
        d = v;
      end
    end
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (!(rdy1 && rdy3) && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (!(rdy1 && rdy3)) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got %b%b expected 11", rdy1, rdy3);
    end
  endtask

  task automatic xact(input logic rw, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] tdat, input logic terr, input bit use_tbl,
                      input string tag);
    logic [31:0] md, d1, d3;
    logic me, e1, e3;
    int lat1, lat3, np1, np3;
    model(rw, sz, uns, a, wd, md, me);
    if (use_tbl) begin
      md = tdat;
      me = terr;
    end
    wait_ready(40);
    req_rw = rw; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    valid1 = 1'b1; valid3 = 1'b1;
    lat1 = -1; lat3 = -1; np1 = 0; np3 = 0;
    d1 = 'x; d3 = 'x; e1 = 1'bx; e3 = 1'bx;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      valid1 = 1'b0; valid3 = 1'b0;
      if (rv1) begin np1++; if (lat1 < 0) begin lat1 = c; d1 = rd1; e1 = re1; end end
      if (rv3) begin np3++; if (lat3 < 0) begin lat3 = c; d3 = rd3; e3 = re3; end end
    end
    chk({tag, "_lat1"}, lat1, 1);
    chk({tag, "_lat3"}, lat3, 3);
    chk({tag, "_pulses1"}, np1, 1);
    chk({tag, "_pulses3"}, np3, 1);
    chk({tag, "_rdata1"}, d1, md);
    chk({tag, "_err1"}, 32'(e1), 32'(me));
    chk({tag, "_rdata3"}, d3, md);
    chk({tag, "_err3"}, 32'(e3), 32'(me));
  endtask

  initial begin
    int n, np1, np3, acc1, acc3, f1, l1, f3, l3;
    model_clear();

    // Reset state and clear sequence
    repeat (3) @(negedge clock);
    chk("rst_outs1", {rdy1, rv1, re1, cd1, |rd1}, 5'b0);
    chk("rst_outs3", {rdy3, rv3, re3, cd3, |rd3}, 5'b0);
    reset = 1'b0;
    n = 0;
    while (!rdy3 && n < 40) begin
      @(negedge clock);
      n++;
      if (n < 16) chk("clear_ready_low", {rdy1, rdy3, cd1, cd3}, 4'b0);
    end
    chk("clear_cycles", n, 16);
    chk("clear_done", {cd1, cd3}, 2'b11);

    // Directed vectors (memory is all-zero after clear)
    tbl.push_back(vec_t'{1'b0, SZ_WORD, 1'b0, 32'h3008, 32'h0,         32'h0,         1'b0});
    tbl.push_back(vec_t'{1'b1, SZ_WORD, 1'b0, 32'h3004, 32'hDEAD_BEEF, 32'h0,         1'b0});
    tbl.push_back(vec_t'{1'b0, SZ_WORD, 1'b0, 32'h3004, 32'h0,         32'hDEAD_BEEF, 1'b0});
    tbl.push_back(vec_t'{1'b1, SZ_BYTE, 1'b0, 32'h3011, 32'h0000_0080, 32'h0,         1'b0});
    tbl.push_back(vec_t'{1'b0, SZ_BYTE, 1'b0, 32'h3011, 32'h0,         32'hFFFF_FF80, 1'b0});
    tbl.push_back(vec_t'{1'b0, SZ_BYTE, 1'b1, 32'h3011, 32'h0,         32'h0000_0080, 1'b0});
    tbl.push_back(vec_t'{1'b1, SZ_HALF, 1'b0, 32'h3012, 32'h0000_1234, 32'h0,         1'b0});
    tbl.push_back(vec_t'{1'b0, SZ_WORD, 1'b0, 32'h3010, 32'h0,         32'h1234_8000, 1'b0});
    tbl.push_back(vec_t'{1'b1, SZ_WORD, 1'b0, 32'h3000, 32'hA5A5_5A5A, 32'h0,         1'b0});
    tbl.push_back(vec_t'{1'b1, SZ_HALF, 1'b0, 32'h3001, 32'h0000_FFFF, 32'h0,         1'b1});
    tbl.push_back(vec_t'{1'b0, SZ_WORD, 1'b0, 32'h3000, 32'h0,         32'hA5A5_5A5A, 1'b0});
    tbl.push_back(vec_t'{1'b1, SZ_WORD, 1'b0, 32'h3002, 32'h0,         32'h0,         1'b1});
    tbl.push_back(vec_t'{1'b0, SZ_WORD, 1'b0, 32'h3000, 32'h0,         32'hA5A5_5A5A, 1'b0});
    tbl.push_back(vec_t'{1'b1, SZ_WORD, 1'b0, 32'h2FFC, 32'h1111_1111, 32'h0,         1'b1});
    tbl.push_back(vec_t'{1'b0, SZ_WORD, 1'b0, 32'h3000, 32'h0,         32'hA5A5_5A5A, 1'b0});
    tbl.push_back(vec_t'{1'b0, SZ_WORD, 1'b0, 32'h3040, 32'h0,         32'h0,         1'b1});
    tbl.push_back(vec_t'{1'b0, SZ_WORD, 1'b0, 32'h3000, 32'h0,         32'hA5A5_5A5A, 1'b0});
    tbl.push_back(vec_t'{1'b1, SZ_RSVD, 1'b0, 32'h3000, 32'h0,         32'h0,         1'b1});
    tbl.push_back(vec_t'{1'b0, SZ_WORD, 1'b0, 32'h3000, 32'h0,         32'hA5A5_5A5A, 1'b0});
    tbl.push_back(vec_t'{1'b0, SZ_WORD, 1'b0, 32'h303C, 32'h0,         32'h0,         1'b0});
    tbl.push_back(vec_t'{1'b1, SZ_BYTE, 1'b0, 32'h303F, 32'h0000_007F, 32'h0,         1'b0});
    tbl.push_back(vec_t'{1'b0, SZ_HALF, 1'b0, 32'h303E, 32'h0,         32'h0000_7F00, 1'b0});
    tbl.push_back(vec_t'{1'b1, SZ_HALF, 1'b0, 32'h3000, 32'hFFFF_8001, 32'h0,         1'b0});
    tbl.push_back(vec_t'{1'b0, SZ_HALF, 1'b0, 32'h3000, 32'h0,         32'hFFFF_8001, 1'b0});
    tbl.push_back(vec_t'{1'b0, SZ_WORD, 1'b0, 32'h3000, 32'h0,         32'hA5A5_8001, 1'b0});
    foreach (tbl[i])
      xact(tbl[i].rw, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd,
           tbl[i].exp_d, tbl[i].exp_e, 1'b1, $sformatf("t%0d", i));

    // Randomized traffic against the reference memory
    for (int i = 0; i < 40; i++)
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           32'h2FF8 + 32'($urandom_range(0, 79)), $urandom, '0, 1'b0, 1'b0,
           $sformatf("r%0d", i));

    // Back-to-back: valid held high for four loads on each instance
    wait_ready(40);
    req_rw = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h3004;
    valid1 = 1'b1; valid3 = 1'b1;
    acc1 = 0; acc3 = 0; np1 = 0; np3 = 0; f1 = -1; l1 = -1; f3 = -1; l3 = -1;
    for (int c = 0; c < 40; c++) begin
      if (valid1 && rdy1) acc1++;
      if (valid3 && rdy3) acc3++;
      @(negedge clock);
      if (acc1 == 4) valid1 = 1'b0;
      if (acc3 == 4) valid3 = 1'b0;
      if (rv1) begin np1++; if (f1 < 0) f1 = c; l1 = c; end
      if (rv3) begin np3++; if (f3 < 0) f3 = c; l3 = c; end
    end
    chk("b2b_pulses1", np1, 4);
    chk("b2b_pulses3", np3, 4);
    chk("b2b_span1", l1 - f1, 3 * 2);
    chk("b2b_span3", l3 - f3, 3 * 4);

    // Reset in the WAIT cycle of the LATENCY=3 instance
    xact(1'b1, SZ_WORD, 1'b0, 32'h3008, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, "pre_st");
    xact(1'b0, SZ_WORD, 1'b0, 32'h3008, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, "pre_ld");
    wait_ready(40);
    req_rw = 1'b0; req_size = SZ_WORD; req_addr = 32'h3008;
    valid1 = 1'b1; valid3 = 1'b1;
    @(negedge clock);
    valid1 = 1'b0; valid3 = 1'b0;
    chk("mid_pre_resp", {rv1, rv3}, 2'b10);
    reset = 1'b1;
    #1;
    chk("mid_rst_outs1", {rdy1, rv1, re1, cd1, |rd1}, 5'b0);
    chk("mid_rst_outs3", {rdy3, rv3, re3, cd3, |rd3}, 5'b0);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    n = 0; np3 = 0;
    while (!rdy3 && n < 40) begin
      @(negedge clock);
      n++;
      if (rv3) np3++;
    end
    chk("mid_clear_cycles", n, 16);
    chk("mid_no_resp", np3, 0);
    xact(1'b0, SZ_WORD, 1'b0, 32'h3008, 32'h0, 32'h0, 1'b0, 1'b1, "post_clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
